clk_div_sched: RTL and testbench
================================

Name: clk_div_sched

Overview:
Run-time controller for the team's integer clock divider.
- Owns the divide ratio and sequences start, stop and ratio changes.
- Produces a single-clock-domain divided level plus a one-cycle period tick.
- All changes take effect only at period boundaries, so consumers never see a runt or stretched period.
- Sits between the register/config interface and the divided-clock consumers, which use div_tick as a clock enable.

Parameters:
- DIV_W, 4: width of the divisor and of the internal period counter.
- DIV_RST, 15: divisor loaded at reset; must be 2..2^DIV_W-1.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: run request. 1 = divider runs; 0 = stop at the next period boundary.
- cfg_valid, input, 1: new-divisor request.
- cfg_div, input, DIV_W: requested divisor N.
- cfg_ready, output, 1: controller can accept a request.
- cfg_err, output, 1: one-cycle pulse when an accepted cfg_div is below 2. The request is dropped.
- div_tick, output, 1: one-cycle pulse on the first cycle of each divided period.
- div_level, output, 1: divided waveform. High for floor(N/2) cycles, then low for the remaining N-floor(N/2) cycles.
- cur_div, output, DIV_W: divisor currently in force.
- busy, output, 1: state is not STOP.

Behaviour:
- Reset (rst=1 at a clk edge): state=STOP, cnt=0, cur_div=DIV_RST, no pending request. Outputs: cfg_ready=1, cfg_err=0, div_tick=0, div_level=0, busy=0. Reset has priority over every other event, including mid-period and mid-switch; the pending request is discarded.
- Handshake: a request is accepted when cfg_valid && cfg_ready at a clk edge. cfg_div is sampled on that edge. cfg_ready=0 only in state SWITCH (one request pending).
- Request with cfg_div<2: accepted, cfg_err pulses on the next cycle, state unchanged.
- STOP:
  - Accepted valid request updates cur_div on the next cycle.
  - en=1 moves to RUN with cnt=0. The first div_tick appears in the first RUN cycle, i.e. 1 cycle after en is sampled.
- RUN:
  - cnt counts 0..cur_div-1 and wraps to 0.
  - div_tick = RUN/SWITCH && cnt==0.
  - div_level = RUN/SWITCH && cnt < floor(cur_div/2).
  - Accepted valid request goes to pending register and moves to SWITCH.
- SWITCH: counting continues with the old cur_div. On the cycle where cnt==cur_div-1:
  - cur_div <= pending, cnt <= 0, then RUN.
  - The next period uses the new N and starts with a tick.
- Stop handling: if en=0 is sampled in the cnt==cur_div-1 cycle (RUN or SWITCH), next state is STOP and cnt=0. Any pending divisor is applied to cur_div at the same time. div_level and div_tick are 0 in STOP.
- Simultaneous events at a boundary: the new divisor and the stop both take effect. en=0 then en=1 within the same period has no effect.
- A cfg_valid held high while cfg_ready=0 waits; it is not lost and not duplicated.
- Arithmetic:
  - cnt is DIV_W bits, unsigned; its comparison with cur_div-1 is done at DIV_W bits.
  - With N=2^DIV_W-1, cnt reaches its maximum legal value with no overflow.

Optional Feature:
- Macro: CLK_DIV_SCHED_PCNT_EN.
- Defined: adds output port period_cnt, 16 bits. It increments (wrapping) on every div_tick, resets to 0 on rst, and holds in STOP.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package clk_div_pkg holds:
  - state enum STOP/RUN/SWITCH, 2-bit encoding 00/01/10;
  - constant DIV_MIN=2;
  - the default DIV_W.
- One sub-module, clk_div_core:
  - contains the cnt counter, the wrap compare and the tick/level decode;
  - inputs: run, load, div value;
  - outputs: tick, level, last (cnt==div-1).
- The top level keeps the FSM, the handshake, the pending register and the optional counter.

Test Plan:
- Reset value, then en=1: busy=1; div_tick every 15 cycles; div_level high 7, low 8; cur_div=15.
- In STOP, request cfg_div=4, then en=1: cur_div=4 one cycle after accept; ticks every 4 cycles; level 2 high/2 low.
- Running at N=5, request N=3 at cnt=1:
  - cfg_ready=0 until the boundary;
  - the remaining period length is 5;
  - following periods are 3 cycles with level 1/2;
  - cfg_ready returns to 1.
- Request cfg_div=1 or 0: cfg_err single pulse one cycle later; cur_div and period unchanged.
- en=0 at cnt=2 with N=6: the period completes (6 cycles total), then STOP with div_level=0 and no further ticks. Also drop en on the last cycle together with a pending N=9: stops, and cur_div=9.
- rst asserted in SWITCH: all reset values next cycle and pending discarded. With CLK_DIV_SCHED_PCNT_EN defined, period_cnt=0 after reset and equals 3 after 3 ticks.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run-time clock divider controller.
package clk_div_pkg;

    // Controller states: STOP (idle), RUN (dividing), SWITCH (new divisor pending)
    typedef enum logic [1:0] {
        STOP   = 2'b00,
        RUN    = 2'b01,
        SWITCH = 2'b10
    } state_t;

    // Smallest divisor that still produces a distinct high and low phase
    localparam int DIV_MIN = 2;

    // Default divisor / period counter width
    localparam int DIV_W_DEF = 4;

endpackage

// File: rtl/clk_div_core.sv
// Period counter for the clock divider: counts 0..div-1 while running and
// decodes the period tick, the divided level and the last-cycle flag.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             level,
    output logic             last
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_m1;
    logic [DIV_W-1:0] half;

    // Wrap point and high-phase length, both kept at DIV_W bits so N=2^DIV_W-1 never overflows
    assign div_m1 = div - 1'b1;
    assign half   = div >> 1;

    // Period counter: load clears, running counts and wraps on the last cycle, idle holds zero
    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Tick on the first cycle, level high for floor(div/2) cycles, both gated off when idle
    always_comb begin
        last  = (cnt == div_m1);
        tick  = run && (cnt == '0);
        level = run && (cnt < half);
    end

endmodule

// File: rtl/clk_div_sched.sv
// Run-time controller for the integer clock divider. Owns the divisor,
// sequences start/stop/ratio changes so that every change lands on a
// period boundary, and drives the divided level plus the period tick.
// Optional feature macro: CLK_DIV_SCHED_PCNT_EN adds a 16-bit period_cnt
// output counting div_tick pulses.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_RST = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_tick,
    output logic             div_level,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy
`ifdef CLK_DIV_SCHED_PCNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cur_div_nxt;
    logic [DIV_W-1:0] pend_div, pend_div_nxt;
    logic             err_nxt;
    logic             accept;
    logic             div_ok;
    logic             take;
    logic             last;
    logic             run;

    assign accept = cfg_valid && cfg_ready;
    assign div_ok = (cfg_div >= DIV_MIN_V);
    assign take   = accept && div_ok;
    assign run    = (state != STOP);

    clk_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk   (clk),
        .run   (run),
        .load  (rst),
        .div   (cur_div),
        .tick  (div_tick),
        .level (div_level),
        .last  (last)
    );

    // State, divisor in force and error pulse registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= STOP;
            cur_div <= DIV_RST_V;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur_div <= cur_div_nxt;
            cfg_err <= err_nxt;
        end
    end

    // Pending divisor holds data only; it is meaningful solely while in SWITCH
    always_ff @(posedge clk) begin
        pend_div <= pend_div_nxt;
    end

    // Next-state logic: requests and stops only change the divider at a period boundary
    always_comb begin
        state_nxt    = state;
        cur_div_nxt  = cur_div;
        pend_div_nxt = pend_div;
        err_nxt      = accept && !div_ok;
        cfg_ready    = (state != SWITCH);
        busy         = (state != STOP);

        case (state)
            STOP: begin
                if (take) begin
                    cur_div_nxt = cfg_div;
                end
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (take) begin
                    if (last && !en) begin
                        // Stopping on this boundary: apply the divisor now rather than lose it
                        cur_div_nxt = cfg_div;
                    end else begin
                        pend_div_nxt = cfg_div;
                        state_nxt    = SWITCH;
                    end
                end
                if (last && !en) begin
                    state_nxt = STOP;
                end
            end
            SWITCH: begin
                if (last) begin
                    cur_div_nxt = pend_div;
                    state_nxt   = en ? RUN : STOP;
                end
            end
            default: begin
                state_nxt = STOP;
            end
        endcase
    end

`ifdef CLK_DIV_SCHED_PCNT_EN
    // Period counter: one increment per tick, wraps at 16 bits, idle in STOP since no ticks occur
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (div_tick) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// period-level behavioural model.
module tb_clk_div_sched;

    localparam int DIV_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_tick;
    logic             div_level;
    logic [DIV_W-1:0] cur_div;
    logic             busy;
`ifdef CLK_DIV_SCHED_PCNT_EN
    logic [15:0]      period_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    clk_div_sched #(
        .DIV_W   (DIV_W),
        .DIV_RST (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_tick  (div_tick),
        .div_level (div_level),
        .cur_div   (cur_div),
        .busy      (busy)
`ifdef CLK_DIV_SCHED_PCNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", nm, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // A divider is either idle or somewhere inside a period of length m_n;
    // a requested divisor waits (m_pv) until the current period ends.
    bit mdl_on = 0;
    bit m_run, m_pv, m_err, m_acc, m_good;
    int m_pos, m_n, m_pend, m_pcnt;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_pos = 0; m_n = 15; m_pv = 0; m_pend = 0;
            m_err = 0; m_pcnt = 0; mdl_on = 1;
        end else begin
            m_acc  = cfg_valid && !m_pv;
            m_good = m_acc && (int'(cfg_div) >= 2);
            m_err  = m_acc && (int'(cfg_div) < 2);
            if (m_run && m_pos == 0) m_pcnt = (m_pcnt + 1) % 65536;
            if (!m_run) begin
                if (m_good) m_n = int'(cfg_div);
                if (en) begin
                    m_run = 1;
                    m_pos = 0;
                end
            end else if (m_pos == m_n - 1) begin
                m_pos = 0;
                if (m_pv) begin
                    m_n  = m_pend;
                    m_pv = 0;
                end else if (m_good && !en) begin
                    m_n = int'(cfg_div);
                end else if (m_good) begin
                    m_pend = int'(cfg_div);
                    m_pv   = 1;
                end
                if (!en) m_run = 0;
            end else begin
                m_pos++;
                if (m_good) begin
                    m_pend = int'(cfg_div);
                    m_pv   = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("m_tick",  int'(div_tick),  int'(m_run && m_pos == 0));
            chk("m_level", int'(div_level), int'(m_run && m_pos < m_n / 2));
            chk("m_busy",  int'(busy),      int'(m_run));
            chk("m_ready", int'(cfg_ready), int'(!m_pv));
            chk("m_err",   int'(cfg_err),   int'(m_err));
            chk("m_cur",   int'(cur_div),   m_n);
`ifdef CLK_DIV_SCHED_PCNT_EN
            chk("m_pcnt",  int'(period_cnt), m_pcnt);
`endif
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_tick(input string nm);
        int k = 0;
        @(negedge clk);
        while (!div_tick && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!div_tick) timeout(nm);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (busy) timeout(nm);
    endtask

    // Called on a tick cycle; returns at the next tick with the period length and high count
    task automatic measure(output int len, output int high);
        len  = 0;
        high = 0;
        do begin
            high += int'(div_level);
            len++;
            @(negedge clk);
        end while (!div_tick && len < 40);
    endtask

    int len, high, t0, nt;

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_busy",  int'(busy), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_cur",   int'(cur_div), 15);
        chk("rst_tick",  int'(div_tick), 0);
        chk("rst_level", int'(div_level), 0);
        chk("rst_err",   int'(cfg_err), 0);

        // Start at N=15: tick one cycle after en, period 15, 7 high
        en = 1'b1;
        @(negedge clk);
        chk("first_tick", int'(div_tick), 1);
        chk("run_busy",   int'(busy), 1);
        measure(len, high);
        chk("n15_len",  len, 15);
        chk("n15_high", high, 7);
        chk("n15_cur",  int'(cur_div), 15);

        // Stop, reconfigure to 4 while idle, restart
        en = 1'b0;
        wait_idle("stop15");
        cfg_valid = 1'b1; cfg_div = 4'd4;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("stop_cfg_cur", int'(cur_div), 4);
        en = 1'b1;
        @(negedge clk);
        chk("n4_tick", int'(div_tick), 1);
        measure(len, high);
        chk("n4_len",  len, 4);
        chk("n4_high", high, 2);

        // Go to N=5, then request N=3 at cnt=1
        cfg_valid = 1'b1; cfg_div = 4'd5;
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_tick("to5");
        chk("n5_cur", int'(cur_div), 5);
        t0 = cyc;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_div = 4'd3;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("sw_ready_lo_a", int'(cfg_ready), 0);
        repeat (2) @(negedge clk);
        chk("sw_ready_lo_b", int'(cfg_ready), 0);
        wait_tick("to3");
        chk("sw_old_len", cyc - t0, 5);
        chk("sw_ready_hi", int'(cfg_ready), 1);
        chk("n3_cur", int'(cur_div), 3);
        measure(len, high);
        chk("n3_len",  len, 3);
        chk("n3_high", high, 1);

        // Illegal divisors 1 and 0
        cfg_valid = 1'b1; cfg_div = 4'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("err1_pulse", int'(cfg_err), 1);
        chk("err1_cur",   int'(cur_div), 3);
        @(negedge clk);
        chk("err1_end",   int'(cfg_err), 0);
        cfg_valid = 1'b1; cfg_div = 4'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("err0_pulse", int'(cfg_err), 1);
        @(negedge clk);
        chk("err0_end",   int'(cfg_err), 0);
        wait_tick("err_tick");
        measure(len, high);
        chk("err_len", len, 3);

        // N=6, drop en at cnt=2: period completes then stops
        cfg_valid = 1'b1; cfg_div = 4'd6;
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_tick("to6");
        chk("n6_cur", int'(cur_div), 6);
        len = 1;
        @(negedge clk); len++;
        @(negedge clk); len++;
        en = 1'b0;
        nt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy) break;
            nt += int'(div_tick);
            len++;
        end
        chk("stop6_len",   len, 6);
        chk("stop6_ticks", nt, 0);
        chk("stop6_busy",  int'(busy), 0);
        chk("stop6_level", int'(div_level), 0);
        nt = 0;
        repeat (5) begin
            @(negedge clk);
            nt += int'(div_tick) + int'(div_level);
        end
        chk("stop6_quiet", nt, 0);

        // Stop on the last cycle together with pending N=9
        en = 1'b1;
        @(negedge clk);
        chk("n6b_tick", int'(div_tick), 1);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_div = 4'd9;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("stop9_busy", int'(busy), 0);
        chk("stop9_cur",  int'(cur_div), 9);
        chk("stop9_tick", int'(div_tick), 0);

        // Reset while a switch is pending
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_div = 4'd4;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("sw_pend_ready", int'(cfg_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("swrst_busy",  int'(busy), 0);
        chk("swrst_ready", int'(cfg_ready), 1);
        chk("swrst_cur",   int'(cur_div), 15);
        chk("swrst_tick",  int'(div_tick), 0);
        chk("swrst_level", int'(div_level), 0);
`ifdef CLK_DIV_SCHED_PCNT_EN
        chk("pcnt_rst", int'(period_cnt), 0);
`endif
        @(negedge clk);
        chk("swrst_tick1", int'(div_tick), 1);
        measure(len, high);
        chk("swrst_len", len, 15);
        measure(len, high);
        @(negedge clk);
`ifdef CLK_DIV_SCHED_PCNT_EN
        chk("pcnt_3", int'(period_cnt), 3);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = DIV_W'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst = 1'b0; cfg_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
